// File: rtl/keccak_squeeze_unit_if.sv
// Lane output stream of the Keccak squeeze unit.
// The squeeze unit is the master. The output formatter is the slave.
interface keccak_squeeze_unit_if #(
   parameter int IDX_W     = 5,
   parameter int LANE_SIZE = 64
);
   logic                 lane_valid_o;
   logic                 lane_ready_i;
   logic [LANE_SIZE-1:0] lane_data_o;
   logic [IDX_W-1:0]     lane_idx_o;
   logic                 lane_last_o;

   modport master (
      output lane_valid_o,
      input  lane_ready_i,
      output lane_data_o,
      output lane_idx_o,
      output lane_last_o
   );

   modport slave (
      input  lane_valid_o,
      output lane_ready_i,
      input  lane_data_o,
      input  lane_idx_o,
      input  lane_last_o
   );
endinterface

// File: rtl/keccak_squeeze_unit.sv
// Keccak squeeze unit.
// On start_i, the unit snapshots the 5x5x64 state. It then streams the first
// rate lanes, one 64-bit lane per transfer, in FIPS 202 order (i = x + 5*y).
// The lanes go out over a valid/ready interface.
module keccak_squeeze_unit #(
   parameter int MAX_RATE_LANES = 21,
   parameter int IDX_W          = 5,
   localparam int ROW_SIZE      = 5,
   localparam int COL_SIZE      = 5,
   localparam int LANE_SIZE     = 64
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 start_i,
   input  logic [IDX_W-1:0]                     rate_lanes_i,
   input  logic [ROW_SIZE*COL_SIZE*LANE_SIZE-1:0] state_i,
   keccak_squeeze_unit_if.master                lane,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 err_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // The snapshot uses the same layout as state_i: [x][y][bit], x most significant.
   typedef logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] keccak_state_t;

   state_t        state_q, state_d;
   keccak_state_t snap_q,  snap_d;
   logic [IDX_W-1:0] rate_q, rate_d;
   logic [2:0]    x_q, x_d;
   logic [2:0]    y_q, y_d;
   logic          err_q, err_d;

   logic          rate_legal;
   logic          streaming;
   logic [IDX_W-1:0] lane_idx;
   logic          lane_is_last;

   // The rate is legal in the range 1..MAX_RATE_LANES.
   assign rate_legal = (rate_lanes_i != '0) &&
                       (rate_lanes_i <= IDX_W'(MAX_RATE_LANES));

   assign streaming = (state_q == ST_STREAM);

   // The lane index is x + 5*y, computed as x + 4*y + y, so no multiplier is needed.
   assign lane_idx = IDX_W'(x_q) + IDX_W'({y_q, 2'b00}) + IDX_W'(y_q);

   assign lane_is_last = (lane_idx == (rate_q - IDX_W'(1)));

   // Next-state logic: capture on a legal start, advance x/y on each transfer.
   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      rate_d  = rate_q;
      x_d     = x_q;
      y_d     = y_q;
      err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (rate_legal) begin
                  snap_d  = keccak_state_t'(state_i);
                  rate_d  = rate_lanes_i;
                  x_d     = 3'd0;
                  y_d     = 3'd0;
                  state_d = ST_STREAM;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            // Valid is always high here, so ready alone marks a transfer.
            // A start_i seen here is ignored.
            if (lane.lane_ready_i) begin
               if (lane_is_last) begin
                  state_d = ST_DONE;
               end else if (x_q == 3'd4) begin
                  x_d = 3'd0;
                  y_d = y_q + 3'd1;
               end else begin
                  x_d = x_q + 3'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers. An asynchronous reset abandons any in-flight stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         rate_q  <= '0;
         x_q     <= 3'd0;
         y_q     <= 3'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         rate_q  <= rate_d;
         x_q     <= x_d;
         y_q     <= y_d;
         err_q   <= err_d;
      end
   end

   // Outputs are decoded from registered state.
   // Lane fields are forced to zero whenever valid is low.
   always_comb begin
      lane.lane_valid_o = streaming;
      lane.lane_data_o  = '0;
      lane.lane_idx_o   = '0;
      lane.lane_last_o  = 1'b0;
      busy_o            = streaming;
      done_o            = (state_q == ST_DONE);
      err_o             = err_q;
      if (streaming) begin
         lane.lane_data_o = snap_q[x_q][y_q];
         lane.lane_idx_o  = lane_idx;
         lane.lane_last_o = lane_is_last;
      end
   end

endmodule

// File: tb/tb_keccak_squeeze_unit.sv
// Directed testbench for keccak_squeeze_unit.
module tb_keccak_squeeze_unit;

   logic         clk;
   logic         rst;
   logic         start_i;
   logic [4:0]   rate_lanes_i;
   logic [1599:0] state_i;
   logic         busy_o;
   logic         done_o;
   logic         err_o;

   logic [4:0][4:0][63:0] st;
   assign state_i = st;

   int checks;
   int failures;

   keccak_squeeze_unit_if #(.IDX_W(5), .LANE_SIZE(64)) lane_if ();

   keccak_squeeze_unit #(.MAX_RATE_LANES(21), .IDX_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start_i),
      .rate_lanes_i (rate_lanes_i),
      .state_i      (state_i),
      .lane         (lane_if),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_sequential();
      for (int x = 0; x < 5; x++)
         for (int y = 0; y < 5; y++)
            st[x][y] = 64'(5 * y + x);
   endtask

   initial begin
      int exp_idx;
      int cyc;
      logic rdy;

      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      start_i  = 1'b0;
      rate_lanes_i = 5'd0;
      st       = '0;
      lane_if.lane_ready_i = 1'b0;

      // Reset state
      #12;
      check("rst_valid", 64'(lane_if.lane_valid_o), 64'd0);
      check("rst_busy",  64'(busy_o), 64'd0);
      check("rst_done",  64'(done_o), 64'd0);
      check("rst_err",   64'(err_o), 64'd0);
      check("rst_data",  lane_if.lane_data_o, 64'd0);
      check("rst_idx",   64'(lane_if.lane_idx_o), 64'd0);
      check("rst_last",  64'(lane_if.lane_last_o), 64'd0);
      step();
      rst = 1'b0;
      step();

      // Sequential pattern with rate 17 and ready held high
      fill_sequential();
      lane_if.lane_ready_i = 1'b1;
      rate_lanes_i = 5'd17;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      st = '1;
      for (int i = 0; i < 17; i++) begin
         check("seq_valid", 64'(lane_if.lane_valid_o), 64'd1);
         check("seq_busy",  64'(busy_o), 64'd1);
         check("seq_idx",   64'(lane_if.lane_idx_o), 64'(i));
         check("seq_data",  lane_if.lane_data_o, 64'(i));
         check("seq_last",  64'(lane_if.lane_last_o), (i == 16) ? 64'd1 : 64'd0);
         $display("seq lane idx=%0d data=%0h last=%0b", lane_if.lane_idx_o, lane_if.lane_data_o, lane_if.lane_last_o);
         step();
      end
      check("seq_done",     64'(done_o), 64'd1);
      check("seq_done_val", 64'(lane_if.lane_valid_o), 64'd0);
      check("seq_done_bsy", 64'(busy_o), 64'd0);
      check("seq_done_dat", lane_if.lane_data_o, 64'd0);
      step();
      check("seq_post_done", 64'(done_o), 64'd0);
      check("seq_post_busy", 64'(busy_o), 64'd0);

      // A single set bit at state[1][0], rate 21
      st = '0;
      st[1][0] = 64'h1;
      rate_lanes_i = 5'd21;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 21; i++) begin
         check("bit_idx",  64'(lane_if.lane_idx_o), 64'(i));
         check("bit_data", lane_if.lane_data_o, (i == 1) ? 64'h1 : 64'h0);
         check("bit_last", 64'(lane_if.lane_last_o), (i == 20) ? 64'd1 : 64'd0);
         $display("bit lane idx=%0d data=%0h", lane_if.lane_idx_o, lane_if.lane_data_o);
         step();
      end
      check("bit_done", 64'(done_o), 64'd1);
      step();

      // Backpressure with rate 9; ready follows the pattern 1,0,0 repeating
      fill_sequential();
      rate_lanes_i = 5'd9;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      exp_idx = 0;
      cyc = 0;
      while (exp_idx < 9 && cyc < 100) begin
         rdy = (cyc % 3 == 0);
         lane_if.lane_ready_i = rdy;
         check("bp_valid", 64'(lane_if.lane_valid_o), 64'd1);
         check("bp_idx",   64'(lane_if.lane_idx_o), 64'(exp_idx));
         check("bp_data",  lane_if.lane_data_o, 64'(exp_idx));
         check("bp_last",  64'(lane_if.lane_last_o), (exp_idx == 8) ? 64'd1 : 64'd0);
         $display("bp cycle=%0d ready=%0b idx=%0d", cyc, rdy, lane_if.lane_idx_o);
         if (rdy) exp_idx++;
         step();
         cyc++;
      end
      check("bp_count", 64'(exp_idx), 64'd9);
      check("bp_done",  64'(done_o), 64'd1);
      lane_if.lane_ready_i = 1'b1;
      step();

      // Illegal rates
      rate_lanes_i = 5'd0;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("err0_err",   64'(err_o), 64'd1);
      check("err0_busy",  64'(busy_o), 64'd0);
      check("err0_valid", 64'(lane_if.lane_valid_o), 64'd0);
      $display("illegal rate=0 err=%0b", err_o);
      step();
      check("err0_clear", 64'(err_o), 64'd0);
      rate_lanes_i = 5'd22;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("err22_err",   64'(err_o), 64'd1);
      check("err22_busy",  64'(busy_o), 64'd0);
      check("err22_valid", 64'(lane_if.lane_valid_o), 64'd0);
      $display("illegal rate=22 err=%0b", err_o);
      step();
      check("err22_clear", 64'(err_o), 64'd0);
      rate_lanes_i = 5'd1;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("r1_valid", 64'(lane_if.lane_valid_o), 64'd1);
      check("r1_idx",   64'(lane_if.lane_idx_o), 64'd0);
      check("r1_last",  64'(lane_if.lane_last_o), 64'd1);
      check("r1_err",   64'(err_o), 64'd0);
      step();
      check("r1_done",  64'(done_o), 64'd1);
      step();

      // Snapshot isolation and a start while busy
      fill_sequential();
      rate_lanes_i = 5'd5;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            st = '1;
            rate_lanes_i = 5'd3;
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         check("iso_idx",  64'(lane_if.lane_idx_o), 64'(i));
         check("iso_data", lane_if.lane_data_o, 64'(i));
         check("iso_err",  64'(err_o), 64'd0);
         $display("iso lane idx=%0d data=%0h", lane_if.lane_idx_o, lane_if.lane_data_o);
         step();
      end
      start_i = 1'b0;
      check("iso_done", 64'(done_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("iso_no_done",  64'(done_o), 64'd0);
         check("iso_no_valid", 64'(lane_if.lane_valid_o), 64'd0);
      end

      // Reset in the middle of a stream
      fill_sequential();
      rate_lanes_i = 5'd13;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rm_idx", 64'(lane_if.lane_idx_o), 64'(i));
         step();
      end
      check("rm_pre_valid", 64'(lane_if.lane_valid_o), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rm_valid", 64'(lane_if.lane_valid_o), 64'd0);
      check("rm_busy",  64'(busy_o), 64'd0);
      check("rm_done",  64'(done_o), 64'd0);
      check("rm_data",  lane_if.lane_data_o, 64'd0);
      $display("reset asserted mid-stream valid=%0b busy=%0b", lane_if.lane_valid_o, busy_o);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rm_no_done",  64'(done_o), 64'd0);
         check("rm_no_valid", 64'(lane_if.lane_valid_o), 64'd0);
      end
      rate_lanes_i = 5'd2;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      check("rm2_idx0",  64'(lane_if.lane_idx_o), 64'd0);
      check("rm2_data0", lane_if.lane_data_o, 64'd0);
      check("rm2_last0", 64'(lane_if.lane_last_o), 64'd0);
      step();
      check("rm2_idx1",  64'(lane_if.lane_idx_o), 64'd1);
      check("rm2_data1", lane_if.lane_data_o, 64'd1);
      check("rm2_last1", 64'(lane_if.lane_last_o), 64'd1);
      step();
      check("rm2_done",  64'(done_o), 64'd1);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
